// File: rtl/cmd_cfg_mc_pkg.sv
// cmd_cfg_pkg: opcodes, response codes and FSM states shared by cmd_cfg_mc
package cmd_cfg_pkg;
  typedef enum logic [3:0] {
    REQ_BATT  = 4'h1,
    SET_AXIS  = 4'h2,
    SET_THRST = 4'h3,
    CALIBRATE = 4'h6,
    MTRS_OFF  = 4'h7,
    EMER_LAND = 4'h8
  } opcode_t;
  typedef enum logic [2:0] {IDLE, BATT, SPIN, CAL, RESP} state_t;
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;
endpackage

// File: rtl/cmd_cfg_mc_if.sv
// cmd_cfg_mc_if: command/response handshake between the UART wrapper (master) and cmd_cfg_mc (slave)
interface cmd_cfg_mc_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        snd_rsp;
  logic [7:0]  resp;
  modport master (output cmd_rdy, cmd, data, input clr_cmd_rdy, snd_rsp, resp);
  modport slave (input cmd_rdy, cmd, data, output clr_cmd_rdy, snd_rsp, resp);
endinterface

// File: rtl/cmd_cfg_mc_cyc_timer.sv
// cyc_timer: loadable down-counter; done is high for the last enabled cycle of a loaded run
module cyc_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done = en && cnt_q == W'(1);
  always_comb cnt_d = load ? ld_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: decodes UART commands into axis/thrust setpoints, sequences battery, spin-up and calibration (watchdog under CMD_WDOG_EN)
module cmd_cfg_mc import cmd_cfg_pkg::*; #(
  parameter int          NUM_AXES   = 3,
  parameter int          AXIS_W     = 16,
  parameter int          THRST_W    = 9,
  parameter logic [15:0] SPINUP_CYC = 16'd1000,
  parameter logic [23:0] WDOG_CYC   = 24'd5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  cmd_cfg_mc_if.slave                bus,
  output logic [NUM_AXES*AXIS_W-1:0] d_axis,
  output logic [THRST_W-1:0]         thrst,
  input  logic [7:0]                 batt,
  output logic                       strt_cnv,
  input  logic                       cnv_cmplt,
  output logic                       strt_cal,
  output logic                       inertial_cal,
  input  logic                       cal_done,
  output logic                       motors_off,
  output logic                       wdog_trip
);
  state_t state_q, state_d;
  logic [7:0] resp_q, resp_d;
  logic [NUM_AXES*AXIS_W-1:0] axis_q, axis_d;
  logic [THRST_W-1:0] thrst_q, thrst_d;
  logic moff_q, moff_d, ical_q, ical_d, scal_q, scal_d, trip_q, trip_d;
  logic acc, legal, spin_done, wd_exp;
  logic [3:0] op, ch;
  assign op = bus.cmd[3:0];
  assign ch = bus.cmd[7:4];
  assign acc = !rst && state_q == IDLE && bus.cmd_rdy;
  assign legal = (op inside {REQ_BATT, SET_AXIS, SET_THRST, CALIBRATE, MTRS_OFF, EMER_LAND})
                 && !(op == SET_AXIS && int'(ch) >= NUM_AXES);
  assign bus.clr_cmd_rdy = acc;
  assign bus.snd_rsp = state_q == RESP;
  assign bus.resp = resp_q;
  assign strt_cnv = acc && legal && op == REQ_BATT;
  assign strt_cal = scal_q;
  assign inertial_cal = ical_q;
  assign motors_off = moff_q;
  assign d_axis = axis_q;
  assign thrst = thrst_q;
  assign wdog_trip = trip_q;
  cyc_timer #(.W(16)) u_spin (
    .clk(clk), .rst(rst), .load(acc), .en(state_q == SPIN), .ld_val(SPINUP_CYC), .done(spin_done)
  );
`ifdef CMD_WDOG_EN
  cyc_timer #(.W(24)) u_wdog (
    .clk(clk), .rst(rst), .load(acc), .en(!moff_q && state_q == IDLE && !acc), .ld_val(WDOG_CYC), .done(wd_exp)
  );
`else
  assign wd_exp = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    resp_d = resp_q;
    axis_d = axis_q;
    thrst_d = thrst_q;
    moff_d = moff_q;
    ical_d = ical_q;
    scal_d = 1'b0;
    trip_d = trip_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          trip_d = 1'b0;
          state_d = !legal ? RESP : op == REQ_BATT ? BATT : op == CALIBRATE ? SPIN : RESP;
          resp_d = !legal ? NAK : state_d == RESP ? POS_ACK : resp_q;
          if (legal && op == SET_AXIS)
            for (int i = 0; i < NUM_AXES; i++)
              if (int'(ch) == i) axis_d[i*AXIS_W +: AXIS_W] = bus.data[AXIS_W-1:0];
          if (legal && op == SET_THRST) thrst_d = bus.data[THRST_W-1:0];
          if (legal && (op == MTRS_OFF || op == EMER_LAND)) thrst_d = '0;
          if (legal && op == EMER_LAND) axis_d = '0;
          if (legal && op == MTRS_OFF) moff_d = 1'b1;
          if (legal && op == CALIBRATE) moff_d = 1'b0;
        end else if (wd_exp) begin
          axis_d = '0;
          thrst_d = '0;
          trip_d = 1'b1;
        end
      end
      BATT: if (cnv_cmplt) begin
        resp_d = batt;
        state_d = RESP;
      end
      SPIN: if (spin_done) begin
        state_d = CAL;
        scal_d = 1'b1;
        ical_d = 1'b1;
      end
      CAL: if (cal_done) begin
        ical_d = 1'b0;
        resp_d = POS_ACK;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      resp_q <= '0;
      axis_q <= '0;
      thrst_q <= '0;
      moff_q <= 1'b1;
      ical_q <= 1'b0;
      scal_q <= 1'b0;
      trip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q <= resp_d;
      axis_q <= axis_d;
      thrst_q <= thrst_d;
      moff_q <= moff_d;
      ical_q <= ical_d;
      scal_q <= scal_d;
      trip_q <= trip_d;
    end
  end
endmodule

// File: tb/tb_cmd_cfg_mc.sv
// tb_cmd_cfg_mc: vector table, corner sequences and random commands checked against a command-level model
module tb_cmd_cfg_mc;
  localparam int NA = 3;
  localparam int AW = 16;
  localparam int TW = 9;
  localparam logic [15:0] SP = 16'd10;
  typedef struct {
    logic [7:0]       c;
    logic [15:0]      d;
    logic [7:0]       r;
    logic [NA*AW-1:0] ax;
    logic [TW-1:0]    th;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] batt = 8'h00;
  logic cnv_cmplt = 1'b0;
  logic cal_done = 1'b0;
  logic [NA*AW-1:0] d_axis;
  logic [TW-1:0] thrst;
  logic strt_cnv, strt_cal, inertial_cal, motors_off, wdog_trip;
  int n_chk = 0;
  int n_err = 0;
  int lat, n_clr, t_clr, t_cnv, t_cal, t_moff, n_ical;
  logic [7:0] r;
  logic [AW-1:0] m_ax [NA];
  logic [TW-1:0] m_th;
  logic m_moff;
  logic [7:0] m_resp;
  cmd_cfg_mc_if bus();
  cmd_cfg_mc #(
    .NUM_AXES(NA), .AXIS_W(AW), .THRST_W(TW), .SPINUP_CYC(SP), .WDOG_CYC(24'd50)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .d_axis(d_axis), .thrst(thrst), .batt(batt),
    .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
    .cal_done(cal_done), .motors_off(motors_off), .wdog_trip(wdog_trip)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic int m_cmd(input logic [7:0] c, input logic [15:0] d, input logic [7:0] b, input int cnv, input int cal);
    int op, ch;
    op = int'(c[3:0]);
    ch = int'(c[7:4]);
    if (!(op inside {1, 2, 3, 6, 7, 8}) || (op == 2 && ch >= NA)) begin
      m_resp = 8'hEE;
      return 1;
    end
    m_resp = 8'hA5;
    case (op)
      1: begin m_resp = b; return cnv + 1; end
      2: m_ax[ch] = d[AW-1:0];
      3: m_th = d[TW-1:0];
      6: begin m_moff = 1'b0; return 2 + int'(SP) + (cal > 0 ? cal : 0); end
      7: begin m_moff = 1'b1; m_th = '0; end
      default: begin m_th = '0; foreach (m_ax[i]) m_ax[i] = '0; end
    endcase
    return 1;
  endfunction
  task automatic m_reset();
    foreach (m_ax[i]) m_ax[i] = '0;
    m_th = '0;
    m_moff = 1'b1;
    m_resp = 8'h00;
  endtask
  task automatic chk_model(input string tag);
    for (int i = 0; i < NA; i++) chk($sformatf("%s ax%0d", tag, i), 64'(d_axis[i*AW +: AW]), 64'(m_ax[i]));
    chk({tag, " thrst"}, 64'(thrst), 64'(m_th));
    chk({tag, " motors_off"}, 64'(motors_off), 64'(m_moff));
    chk({tag, " resp"}, 64'(r), 64'(m_resp));
  endtask
  task automatic send(input logic [7:0] c, input logic [15:0] d, input int cnv_dly, input int cal_dly, input bit second);
    bit drop;
    drop = 1'b0;
    bus.cmd = c;
    bus.data = d;
    bus.cmd_rdy = 1'b1;
    lat = -1; n_clr = 0; t_clr = -1; t_cnv = -1; t_cal = -1; t_moff = -1; n_ical = 0;
    cal_done = (cal_dly < 0);
    for (int k = 0; k < 300 && lat < 0; k++) begin
      if (drop) begin bus.cmd_rdy = 1'b0; drop = 1'b0; end
      #1;
      if (bus.clr_cmd_rdy) begin n_clr++; if (t_clr < 0) t_clr = k; drop = 1'b1; end
      if (strt_cnv && t_cnv < 0) t_cnv = k;
      if (strt_cal && t_cal < 0) t_cal = k;
      if (!motors_off && t_moff < 0) t_moff = k;
      if (inertial_cal) n_ical++;
      if (bus.snd_rsp) begin lat = k; r = bus.resp; end
      cnv_cmplt = (t_cnv >= 0 && k == t_cnv + cnv_dly);
      if (t_cal >= 0 && k >= t_cal + cal_dly) cal_done = 1'b1;
      if (second && strt_cal) begin bus.cmd = 8'h03; bus.data = 16'h0080; bus.cmd_rdy = 1'b1; end
      @(negedge clk);
    end
    cnv_cmplt = 1'b0;
    cal_done = 1'b0;
    if (lat < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL cmd %0h: no snd_rsp within 300 cycles", c);
      bus.cmd_rdy = 1'b0;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    vec_t tv [12];
    logic [3:0] pool [10];
    logic [3:0] rop, rch;
    logic [15:0] rd;
    int rcnv, rcal, elat, n;
    tv = '{
      '{8'h12, 16'h6543, 8'hA5, 48'h0000_6543_0000, 9'h000},
      '{8'h32, 16'h1111, 8'hEE, 48'h0000_6543_0000, 9'h000},
      '{8'h05, 16'h0000, 8'hEE, 48'h0000_6543_0000, 9'h000},
      '{8'h03, 16'h0013, 8'hA5, 48'h0000_6543_0000, 9'h013},
      '{8'h22, 16'hABCD, 8'hA5, 48'hABCD_6543_0000, 9'h013},
      '{8'h02, 16'h9876, 8'hA5, 48'hABCD_6543_9876, 9'h013},
      '{8'h13, 16'hFFFF, 8'hA5, 48'hABCD_6543_9876, 9'h1FF},
      '{8'hF2, 16'h1111, 8'hEE, 48'hABCD_6543_9876, 9'h1FF},
      '{8'h07, 16'h0000, 8'hA5, 48'hABCD_6543_9876, 9'h000},
      '{8'h03, 16'h0080, 8'hA5, 48'hABCD_6543_9876, 9'h080},
      '{8'h08, 16'h0000, 8'hA5, 48'h0000_0000_0000, 9'h000},
      '{8'h00, 16'hFFFF, 8'hEE, 48'h0000_0000_0000, 9'h000}
    };
    pool = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h2, 4'h0, 4'h5, 4'hF};
    bus.cmd_rdy = 1'b0;
    bus.cmd = 8'h00;
    bus.data = 16'h0000;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset d_axis", 64'(d_axis), 64'd0);
    chk("reset thrst", 64'(thrst), 64'd0);
    chk("reset motors_off", 64'(motors_off), 64'd1);
    chk("reset resp", 64'(bus.resp), 64'd0);
    chk("reset wdog_trip", 64'(wdog_trip), 64'd0);
    chk("reset pulses", 64'({bus.clr_cmd_rdy, bus.snd_rsp, strt_cnv, strt_cal, inertial_cal}), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      void'(m_cmd(tv[i].c, tv[i].d, batt, 1, 0));
      send(tv[i].c, tv[i].d, 1, 0, 1'b0);
      chk($sformatf("vec%0d resp", i), 64'(r), 64'(tv[i].r));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd1);
      chk($sformatf("vec%0d clr count", i), 64'(n_clr), 64'd1);
      chk($sformatf("vec%0d d_axis", i), 64'(d_axis), 64'(tv[i].ax));
      chk($sformatf("vec%0d thrst", i), 64'(thrst), 64'(tv[i].th));
      chk($sformatf("vec%0d motors_off", i), 64'(motors_off), 64'd1);
    end
    batt = 8'h48;
    void'(m_cmd(8'h01, 16'h0000, batt, 20, 0));
    send(8'h01, 16'h0000, 20, 0, 1'b0);
    chk("batt resp", 64'(r), 64'h48);
    chk("batt strt_cnv cycle", 64'(t_cnv), 64'd0);
    chk("batt latency", 64'(lat), 64'd21);
    batt = 8'h00;
    repeat (3) @(negedge clk);
    chk("batt resp held", 64'(bus.resp), 64'h48);
    void'(m_cmd(8'h06, 16'h0000, batt, 1, 5));
    send(8'h06, 16'h0000, 1, 5, 1'b1);
    chk("cal resp", 64'(r), 64'hA5);
    chk("cal motors_off fall", 64'(t_moff), 64'd1);
    chk("cal spinup length", 64'(t_cal - t_moff), 64'(SP));
    chk("cal inertial_cal cycles", 64'(n_ical), 64'd6);
    chk("cal latency", 64'(lat), 64'd17);
    chk("cal pending not cleared", 64'(n_clr), 64'd1);
    chk("cal motors on", 64'(motors_off), 64'd0);
    void'(m_cmd(8'h03, 16'h0080, batt, 1, 0));
    send(8'h03, 16'h0080, 1, 0, 1'b0);
    chk("pending clr at idle", 64'(t_clr), 64'd0);
    chk("pending latency", 64'(lat), 64'd1);
    chk("pending thrst", 64'(thrst), 64'h080);
    void'(m_cmd(8'h06, 16'h0000, batt, 1, -1));
    send(8'h06, 16'h0000, 1, -1, 1'b0);
    chk("cal_done early latency", 64'(lat), 64'd12);
    chk("cal_done early inertial_cal", 64'(n_ical), 64'd1);
    chk_model("cal_done early");
    for (int i = 0; i < 40; i++) begin
      rop = pool[$urandom_range(0, 9)];
      rch = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      rd = 16'($urandom);
      batt = 8'($urandom);
      rcnv = int'($urandom_range(1, 4));
      rcal = int'($urandom_range(0, 4)) - 1;
      elat = m_cmd({rch, rop}, rd, batt, rcnv, rcal);
      send({rch, rop}, rd, rcnv, rcal, 1'b0);
      chk($sformatf("rnd%0d latency", i), 64'(lat), 64'(elat));
      chk($sformatf("rnd%0d clr count", i), 64'(n_clr), 64'd1);
      chk_model($sformatf("rnd%0d", i));
    end
    bus.cmd = 8'h06;
    bus.data = 16'h0000;
    bus.cmd_rdy = 1'b1;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("spin motors on", 64'(motors_off), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst mid-spin motors_off", 64'(motors_off), 64'd1);
    chk("rst mid-spin d_axis", 64'(d_axis), 64'd0);
    chk("rst mid-spin thrst", 64'(thrst), 64'd0);
    chk("rst mid-spin resp", 64'(bus.resp), 64'd0);
    rst = 1'b0;
    m_reset();
    n = 0;
    repeat (15) begin
      @(negedge clk);
      #1 if (strt_cal) n++;
    end
    chk("rst mid-spin no strt_cal", 64'(n), 64'd0);
    @(negedge clk);
    void'(m_cmd(8'h03, 16'h0055, batt, 1, 0));
    send(8'h03, 16'h0055, 1, 0, 1'b0);
    chk("after rst latency", 64'(lat), 64'd1);
    chk_model("after rst");
    void'(m_cmd(8'h06, 16'h0000, batt, 1, 0));
    send(8'h06, 16'h0000, 1, 0, 1'b0);
    void'(m_cmd(8'h03, 16'h0080, batt, 1, 0));
    send(8'h03, 16'h0080, 1, 0, 1'b0);
    chk_model("wdog setup");
`ifdef CMD_WDOG_EN
    n = 0;
    for (int k = 0; k < 200 && thrst != '0; k++) begin
      n++;
      @(negedge clk);
    end
    chk("wdog idle cycles", 64'(n), 64'd50);
    chk("wdog trip", 64'(wdog_trip), 64'd1);
    chk("wdog d_axis", 64'(d_axis), 64'd0);
    chk("wdog no snd_rsp", 64'(bus.snd_rsp), 64'd0);
    foreach (m_ax[i]) m_ax[i] = '0;
    m_th = '0;
    void'(m_cmd(8'h03, 16'h0001, batt, 1, 0));
    send(8'h03, 16'h0001, 1, 0, 1'b0);
    chk("wdog trip cleared", 64'(wdog_trip), 64'd0);
    chk_model("wdog after");
`else
    repeat (100) @(negedge clk);
    chk("no wdog trip", 64'(wdog_trip), 64'd0);
    chk("no wdog thrst kept", 64'(thrst), 64'h080);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
